// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcodes, class indices and decoded-bundle type for the decode stage
package decode_pkg;

    localparam int CLASS_W = 10;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int CLS_LUI    = 0;
    localparam int CLS_AUIPC  = 1;
    localparam int CLS_JAL    = 2;
    localparam int CLS_JALR   = 3;
    localparam int CLS_BRANCH = 4;
    localparam int CLS_LOAD   = 5;
    localparam int CLS_STORE  = 6;
    localparam int CLS_OP_IMM = 7;
    localparam int CLS_OP     = 8;
    localparam int CLS_MISC   = 9;

    // Every base-ISA immediate fits in 32 bits; consumers sign-extend to XLEN.
    typedef struct packed {
        logic [31:0]        instruction;
        logic [6:0]         opcode;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [2:0]         funct3;
        logic [6:0]         funct7;
        logic [31:0]        immediate;
        logic [CLASS_W-1:0] cls;
        logic               illegal;
    } decode_bundle_t;

endpackage

// File: rtl/decode_comb.sv
// rtl/decode_comb.sv - combinational instruction-to-bundle decode; FENCE/SYSTEM gated by DECODE_SYSTEM_EN
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]    instruction,
    output decode_bundle_t bundle
);

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [2:0]  f3;
    logic [6:0]  f7;

    assign f3    = instruction[14:12];
    assign f7    = instruction[31:25];
    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'b0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    always_comb begin
        decode_bundle_t d;
        logic legal;
        d = '0;
        legal = 1'b0;
        d.instruction = instruction;
        if (instruction[1:0] == 2'b11) begin
            d.opcode = instruction[6:0];
            case (instruction[6:0])
                OPC_LUI, OPC_AUIPC: begin
                    legal = 1'b1;
                    d.rd = instruction[11:7];
                    d.immediate = imm_u;
                    d.cls[(instruction[6:0] == OPC_LUI) ? CLS_LUI : CLS_AUIPC] = 1'b1;
                end
                OPC_JAL: begin
                    legal = 1'b1;
                    d.rd = instruction[11:7];
                    d.immediate = imm_j;
                    d.cls[CLS_JAL] = 1'b1;
                end
                OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                    d.rd = instruction[11:7];
                    d.rs1 = instruction[19:15];
                    d.funct3 = f3;
                    d.immediate = imm_i;
                    if (instruction[6:0] == OPC_JALR) begin
                        legal = (f3 == 3'b000);
                        d.cls[CLS_JALR] = 1'b1;
                    end else if (instruction[6:0] == OPC_LOAD) begin
                        legal = !((f3 == 3'b111) ||
                                  (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110)));
                        d.cls[CLS_LOAD] = 1'b1;
                    end else begin
                        legal = 1'b1;
                        d.cls[CLS_OP_IMM] = 1'b1;
                    end
                end
                OPC_BRANCH: begin
                    legal = !(f3 == 3'b010 || f3 == 3'b011);
                    d.rs1 = instruction[19:15];
                    d.rs2 = instruction[24:20];
                    d.funct3 = f3;
                    d.immediate = imm_b;
                    d.cls[CLS_BRANCH] = 1'b1;
                end
                OPC_STORE: begin
                    legal = !(f3[2] || (XLEN == 32 && f3 == 3'b011));
                    d.rs1 = instruction[19:15];
                    d.rs2 = instruction[24:20];
                    d.funct3 = f3;
                    d.immediate = imm_s;
                    d.cls[CLS_STORE] = 1'b1;
                end
                OPC_OP: begin
                    legal = (f7 == 7'b0000000) ||
                            (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
                    d.rd = instruction[11:7];
                    d.rs1 = instruction[19:15];
                    d.rs2 = instruction[24:20];
                    d.funct3 = f3;
                    d.funct7 = f7;
                    d.cls[CLS_OP] = 1'b1;
                end
`ifdef DECODE_SYSTEM_EN
                OPC_FENCE, OPC_SYSTEM: begin
                    legal = !(instruction[6:0] == OPC_SYSTEM && f3 == 3'b100);
                    d.rd = instruction[11:7];
                    d.rs1 = instruction[19:15];
                    d.funct3 = f3;
                    d.immediate = imm_i;
                    d.cls[CLS_MISC] = 1'b1;
                end
`endif
                default: legal = 1'b0;
            endcase
        end
        // Illegal words keep only the raw word and opcode for trap reporting.
        if (!legal) begin
            d.rd = '0;
            d.rs1 = '0;
            d.rs2 = '0;
            d.funct3 = '0;
            d.funct7 = '0;
            d.immediate = '0;
            d.cls = '0;
            d.illegal = 1'b1;
        end
        bundle = d;
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with two-entry skid buffer and flush; DECODE_SYSTEM_EN enables FENCE/SYSTEM
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instruction,
    input  logic [PC_WIDTH-1:0] in_pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [31:0]         out_instruction,
    output logic [6:0]          out_opcode,
    output logic [4:0]          out_rd,
    output logic [4:0]          out_rs1_address,
    output logic [4:0]          out_rs2_address,
    output logic [2:0]          out_funct3,
    output logic [6:0]          out_funct7,
    output logic [XLEN-1:0]     out_immediate,
    output logic [CLASS_W-1:0]  out_class,
    output logic                out_illegal
);

    decode_bundle_t      dec, out_q, skid_q;
    logic [PC_WIDTH-1:0] out_pc_q, skid_pc_q;
    logic                out_valid_q, skid_valid_q;
    logic                in_fire, out_fire;

    decode_comb #(.XLEN(XLEN)) u_decode_comb (
        .instruction (in_instruction),
        .bundle      (dec)
    );

    assign in_ready = !skid_valid_q;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_pc_q     <= '0;
            skid_pc_q    <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (skid_valid_q) begin
            // in_ready is low here, so only the drain of skid into out can happen.
            if (out_fire) begin
                out_q        <= skid_q;
                out_pc_q     <= skid_pc_q;
                skid_valid_q <= 1'b0;
            end
        end else if (in_fire) begin
            if (!out_valid_q || out_ready) begin
                out_q       <= dec;
                out_pc_q    <= in_pc;
                out_valid_q <= 1'b1;
            end else begin
                skid_q       <= dec;
                skid_pc_q    <= in_pc;
                skid_valid_q <= 1'b1;
            end
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_pc          = out_pc_q;
    assign out_instruction = out_q.instruction;
    assign out_opcode      = out_q.opcode;
    assign out_rd          = out_q.rd;
    assign out_rs1_address = out_q.rs1;
    assign out_rs2_address = out_q.rs2;
    assign out_funct3      = out_q.funct3;
    assign out_funct7      = out_q.funct7;
    assign out_immediate   = XLEN'($signed(out_q.immediate));
    assign out_class       = out_q.cls;
    assign out_illegal     = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage at XLEN=32 and XLEN=64
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [31:0] in_instruction, in_pc;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_pc, out_instruction, out_immediate;
    logic [6:0]  out_opcode, out_funct7;
    logic [4:0]  out_rd, out_rs1_address, out_rs2_address;
    logic [2:0]  out_funct3;
    logic [9:0]  out_class;

    logic        in_ready_w, out_valid_w, out_illegal_w;
    logic [31:0] out_pc_w, out_instruction_w;
    logic [63:0] out_immediate_w;
    logic [6:0]  out_opcode_w, out_funct7_w;
    logic [4:0]  out_rd_w, out_rs1_address_w, out_rs2_address_w;
    logic [2:0]  out_funct3_w;
    logic [9:0]  out_class_w;

    int total = 0;
    int passed = 0;

`ifdef DECODE_SYSTEM_EN
    localparam logic [9:0] SYS_CLS = 10'h200;
    localparam logic       SYS_ILL = 1'b0;
`else
    localparam logic [9:0] SYS_CLS = 10'h000;
    localparam logic       SYS_ILL = 1'b1;
`endif

    decode_stage #(.XLEN(32), .PC_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instruction(out_instruction), .out_opcode(out_opcode), .out_rd(out_rd),
        .out_rs1_address(out_rs1_address), .out_rs2_address(out_rs2_address),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_immediate(out_immediate),
        .out_class(out_class), .out_illegal(out_illegal)
    );

    decode_stage #(.XLEN(64), .PC_WIDTH(32)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_instruction(in_instruction), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_pc(out_pc_w),
        .out_instruction(out_instruction_w), .out_opcode(out_opcode_w), .out_rd(out_rd_w),
        .out_rs1_address(out_rs1_address_w), .out_rs2_address(out_rs2_address_w),
        .out_funct3(out_funct3_w), .out_funct7(out_funct7_w), .out_immediate(out_immediate_w),
        .out_class(out_class_w), .out_illegal(out_illegal_w)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_instruction = '0; in_pc = '0;
        step(); step();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        total++; if (out_class !== 10'h0) $display("FAIL reset_class got %h want 0", out_class); else passed++;
        total++; if (out_illegal !== 1'b0) $display("FAIL reset_illegal got %b want 0", out_illegal); else passed++;
        total++; if (out_immediate !== 32'h0) $display("FAIL reset_imm got %h want 0", out_immediate); else passed++;
        total++; if (out_pc !== 32'h0) $display("FAIL reset_pc got %h want 0", out_pc); else passed++;
        rst = 1'b0;
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_addi();
        in_valid = 1'b1; in_instruction = 32'h00500093; in_pc = 32'h100;
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) $display("FAIL addi_valid got %b want 1", out_valid); else passed++;
        total++; if (out_opcode !== 7'b0010011) $display("FAIL addi_opcode got %b want 0010011", out_opcode); else passed++;
        total++; if (out_rd !== 5'd1) $display("FAIL addi_rd got %0d want 1", out_rd); else passed++;
        total++; if (out_rs1_address !== 5'd0) $display("FAIL addi_rs1 got %0d want 0", out_rs1_address); else passed++;
        total++; if (out_funct3 !== 3'd0) $display("FAIL addi_funct3 got %0d want 0", out_funct3); else passed++;
        total++; if (out_immediate !== 32'd5) $display("FAIL addi_imm got %h want 5", out_immediate); else passed++;
        total++; if (out_class !== 10'h080) $display("FAIL addi_class got %h want 080", out_class); else passed++;
        total++; if (out_illegal !== 1'b0) $display("FAIL addi_illegal got %b want 0", out_illegal); else passed++;
        total++; if (out_pc !== 32'h100) $display("FAIL addi_pc got %h want 100", out_pc); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL addi_drain got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_store();
        in_valid = 1'b1; in_instruction = 32'hFE20AE23; in_pc = 32'h104;
        step();
        in_valid = 1'b0;
        total++; if (out_rs1_address !== 5'd1) $display("FAIL sw_rs1 got %0d want 1", out_rs1_address); else passed++;
        total++; if (out_rs2_address !== 5'd2) $display("FAIL sw_rs2 got %0d want 2", out_rs2_address); else passed++;
        total++; if (out_funct3 !== 3'b010) $display("FAIL sw_funct3 got %b want 010", out_funct3); else passed++;
        total++; if (out_immediate !== 32'hFFFFFFFC) $display("FAIL sw_imm got %h want fffffffc", out_immediate); else passed++;
        total++; if (out_class !== 10'h040) $display("FAIL sw_class got %h want 040", out_class); else passed++;
        total++; if (out_rd !== 5'd0) $display("FAIL sw_rd got %0d want 0", out_rd); else passed++;
        total++; if (out_funct7 !== 7'd0) $display("FAIL sw_funct7 got %h want 0", out_funct7); else passed++;
        step();
    endtask

    task automatic test_lui64();
        in_valid = 1'b1; in_instruction = 32'h800002B7; in_pc = 32'h108;
        step();
        in_valid = 1'b0;
        total++; if (out_rd_w !== 5'd5) $display("FAIL lui64_rd got %0d want 5", out_rd_w); else passed++;
        total++; if (out_immediate_w !== 64'hFFFFFFFF80000000) $display("FAIL lui64_imm got %h want ffffffff80000000", out_immediate_w); else passed++;
        total++; if (out_class_w !== 10'h001) $display("FAIL lui64_class got %h want 001", out_class_w); else passed++;
        total++; if (out_immediate !== 32'h80000000) $display("FAIL lui32_imm got %h want 80000000", out_immediate); else passed++;
        step();
    endtask

    task automatic test_compressed();
        in_valid = 1'b1; in_instruction = 32'h00004501; in_pc = 32'h204;
        step();
        in_valid = 1'b0;
        total++; if (out_illegal !== 1'b1) $display("FAIL c_illegal got %b want 1", out_illegal); else passed++;
        total++; if (out_opcode !== 7'd0) $display("FAIL c_opcode got %h want 0", out_opcode); else passed++;
        total++; if (out_class !== 10'h0) $display("FAIL c_class got %h want 0", out_class); else passed++;
        total++; if (out_pc !== 32'h204) $display("FAIL c_pc got %h want 204", out_pc); else passed++;
        total++; if (out_instruction !== 32'h00004501) $display("FAIL c_instr got %h want 00004501", out_instruction); else passed++;
        total++; if (out_rd !== 5'd0) $display("FAIL c_rd got %0d want 0", out_rd); else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] instr_t [12] = '{32'h000090E7, 32'h40001033, 32'h40000033, 32'h00003003,
                                      32'h00002063, 32'h00003023, 32'h0000007F, 32'h008000EF,
                                      32'hFE000EE3, 32'h00000073, 32'h00007003, 32'h00000017};
        logic [9:0]  cls32_t [12] = '{10'h0, 10'h0, 10'h100, 10'h0, 10'h0, 10'h0, 10'h0,
                                      10'h004, 10'h010, SYS_CLS, 10'h0, 10'h002};
        logic        ill32_t [12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                      1'b0, 1'b0, SYS_ILL, 1'b1, 1'b0};
        logic [31:0] imm32_t [12] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                      32'h8, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0};
        logic [9:0]  cls64_t [12] = '{10'h0, 10'h0, 10'h100, 10'h020, 10'h0, 10'h040, 10'h0,
                                      10'h004, 10'h010, SYS_CLS, 10'h0, 10'h002};
        logic        ill64_t [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                                      1'b0, 1'b0, SYS_ILL, 1'b1, 1'b0};
        logic [63:0] imm64_t [12] = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
                                      64'h8, 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h0, 64'h0};
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_instruction = instr_t[i]; in_pc = 32'h400 + 32'(i * 4);
            step();
            total++; if (out_valid !== 1'b1) $display("FAIL vec%0d_valid got %b want 1", i, out_valid); else passed++;
            total++; if (out_pc !== 32'h400 + 32'(i * 4)) $display("FAIL vec%0d_pc got %h want %h", i, out_pc, 32'h400 + 32'(i * 4)); else passed++;
            total++; if (out_class !== cls32_t[i]) $display("FAIL vec%0d_class32 got %h want %h", i, out_class, cls32_t[i]); else passed++;
            total++; if (out_illegal !== ill32_t[i]) $display("FAIL vec%0d_illegal32 got %b want %b", i, out_illegal, ill32_t[i]); else passed++;
            total++; if (out_immediate !== imm32_t[i]) $display("FAIL vec%0d_imm32 got %h want %h", i, out_immediate, imm32_t[i]); else passed++;
            total++; if (out_class_w !== cls64_t[i]) $display("FAIL vec%0d_class64 got %h want %h", i, out_class_w, cls64_t[i]); else passed++;
            total++; if (out_illegal_w !== ill64_t[i]) $display("FAIL vec%0d_illegal64 got %b want %b", i, out_illegal_w, ill64_t[i]); else passed++;
            total++; if (out_immediate_w !== imm64_t[i]) $display("FAIL vec%0d_imm64 got %h want %h", i, out_immediate_w, imm64_t[i]); else passed++;
        end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instruction = 32'h00100093; in_pc = 32'hA0;
        step();
        total++; if (out_pc !== 32'hA0 || out_valid !== 1'b1) $display("FAIL bp_a_load got pc %h v %b want a0 1", out_pc, out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_a got %b want 1", in_ready); else passed++;
        in_instruction = 32'h00200093; in_pc = 32'hB0;
        step();
        total++; if (in_ready !== 1'b0) $display("FAIL bp_ready_b got %b want 0", in_ready); else passed++;
        total++; if (out_pc !== 32'hA0) $display("FAIL bp_hold1 got %h want a0", out_pc); else passed++;
        in_instruction = 32'h00300093; in_pc = 32'hC0;
        step();
        total++; if (in_ready !== 1'b0) $display("FAIL bp_ready_c got %b want 0", in_ready); else passed++;
        total++; if (out_pc !== 32'hA0 || out_immediate !== 32'd1) $display("FAIL bp_hold2 got pc %h imm %h want a0 1", out_pc, out_immediate); else passed++;
        out_ready = 1'b1;
        step();
        total++; if (out_pc !== 32'hB0 || out_immediate !== 32'd2 || out_valid !== 1'b1) $display("FAIL bp_b_out got pc %h imm %h want b0 2", out_pc, out_immediate); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_rel got %b want 1", in_ready); else passed++;
        step();
        in_valid = 1'b0;
        total++; if (out_pc !== 32'hC0 || out_immediate !== 32'd3 || out_valid !== 1'b1) $display("FAIL bp_c_out got pc %h imm %h want c0 3", out_pc, out_immediate); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL bp_drain got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instruction = 32'h00100093; in_pc = 32'h300;
        step();
        in_instruction = 32'h00200093; in_pc = 32'h304;
        step();
        total++; if (in_ready !== 1'b0) $display("FAIL fl_full got %b want 0", in_ready); else passed++;
        in_instruction = 32'h00400093; in_pc = 32'h308; flush = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL fl_out_valid got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL fl_in_ready got %b want 1", in_ready); else passed++;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL fl_no_d got %b want 0", out_valid); else passed++;
        in_valid = 1'b1; in_instruction = 32'h00500093; in_pc = 32'h30C; flush = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL fl_ready_discard got %b want 0", out_valid); else passed++;
        flush = 1'b0; in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL fl_no_e got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instruction = 32'h00100093; in_pc = 32'h500;
        step();
        in_instruction = 32'h00200093; in_pc = 32'h504;
        step();
        in_valid = 1'b0; rst = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL rm_valid got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL rm_ready got %b want 1", in_ready); else passed++;
        total++; if (out_pc !== 32'h0 || out_instruction !== 32'h0) $display("FAIL rm_data got pc %h instr %h want 0 0", out_pc, out_instruction); else passed++;
        rst = 1'b0; out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL rm_after got %b want 0", out_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_store();
        test_lui64();
        test_compressed();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RISC-V base-ISA decode stage that sits between fetch and register read. It accepts one 32-bit instruction plus its PC per valid/ready transfer and extracts the opcode, register addresses, funct fields and immediate, sign-extended to XLEN. It also emits a one-hot instruction class and an illegal-instruction flag. A two-entry skid buffer gives full throughput under backpressure, and a flush input discards in-flight entries on redirect.

## Interface
- XLEN, 32, datapath width (32 or 64); immediates sign-extend to XLEN; RV64-only encodings are legal only when XLEN=64
- PC_WIDTH, 32, width of the PC passthrough
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream has an instruction
- in_ready  output  1  stage can accept; equals !skid_valid (registered)
- in_instruction  input  32  raw instruction word
- in_pc  input  PC_WIDTH  PC of in_instruction
- flush  input  1  discard all held and incoming entries
- out_valid  output  1  decoded bundle present
- out_ready  input  1  downstream accepts bundle
- out_pc  output  PC_WIDTH  PC of bundle
- out_instruction  output  32  raw word, for trap value
- out_opcode  output  7  instruction[6:0]; 0 if bits[1:0]!=2'b11
- out_rd, out_rs1_address, out_rs2_address  output  5 each  register fields; 0 when the format lacks the field
- out_funct3  output  3  0 for U/J formats
- out_funct7  output  7  R-type only, else 0
- out_immediate  output  XLEN  format-specific immediate, sign-extended from instruction[31]; 0 for R-type
- out_class  output  10  one-hot: 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP, 9 MISC (FENCE/SYSTEM); all zero when illegal
- out_illegal  output  1  instruction is not a legal implemented encoding

## Operation
- Combinational decode feeds a bundle register. A skid register catches one extra bundle when out_ready drops.
- Formats: U (LUI/AUIPC) imm={i[31:12],12'b0}. J imm={i[31],i[19:12],i[20],i[30:21],0}. I (JALR/LOAD/OP_IMM) imm=i[31:20]. S imm={i[31:25],i[11:7]}. B imm={i[31],i[7],i[30:25],i[11:8],0}. R has no immediate. Each immediate sign-extends to XLEN, including U-type when XLEN=64.
- Illegal cases:
  - bits[1:0]!=2'b11 (compressed, unsupported)
  - unlisted opcode
  - JALR funct3!=000
  - BRANCH funct3 010/011
  - LOAD funct3 111, or 011/110 when XLEN=32
  - STORE funct3 >=100, or 011 when XLEN=32
  - OP funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101
- An illegal bundle still travels the pipe. All fields except out_pc, out_instruction and out_opcode are zeroed, out_class=0 and out_illegal=1.
- Transfers:
  - Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
  - Input transfer when out is empty or draining: the new bundle loads into out.
  - Input transfer while out is held (out_valid & !out_ready): the new bundle goes to skid.
  - Output transfer with skid full: skid moves to out and skid empties.
- Order is strictly FIFO; no bundle is dropped or duplicated.
- flush: next cycle out_valid=0 and skid empty. An input presented in the flush cycle is discarded even if in_ready=1. flush takes priority over every transfer.

## Timing
- Latency: 1 cycle, from input transfer to out_valid.
- Throughput: 1 per cycle while out_ready=1.
- in_ready is low for exactly the cycles in which skid holds a bundle. It comes straight from a flop, with no combinational path from out_ready.
- Reset: out_valid=0, skid empty, in_ready=1. All data outputs are 0 (out_class=0, out_illegal=0).
- Reset mid-operation drops both entries the next cycle.
- Output fields are stable while out_valid & !out_ready.

## Configuration
- DECODE_SYSTEM_EN
- Defined: opcodes 0001111 (FENCE) and 1110011 (SYSTEM) decode as I-type. They set out_class[9], with rd/rs1/funct3 extracted and imm=i[31:20] (the CSR address or funct12). SYSTEM funct3=100 is illegal.
- Undefined: both opcodes are illegal, and out_class[9] is tied to 0.

## Structure
- Shared package decode_pkg holds:
  - opcode constants (OPC_LUI … OPC_SYSTEM)
  - class bit indices and CLASS_W=10
  - the decoded-bundle struct typedef, used by later pipeline stages
- One sub-module, decode_comb: a pure combinational instruction→bundle decode, reused by future fetch-side predecode.
- decode_stage holds only the out and skid registers plus handshake logic.

## Test plan
- 0x00500093 (ADDI x1,x0,5), out_ready=1 → one cycle later: opcode 0010011, rd=1, rs1=0, funct3=0, imm=5, class bit7, illegal=0.
- 0xFE20AE23 (SW x2,-4(x1)) → rs1=1, rs2=2, funct3=010, imm=0xFFFFFFFC (XLEN=32), class bit6.
- XLEN=64, 0x800002B7 (LUI x5,0x80000) → rd=5, imm=0xFFFFFFFF80000000, class bit0.
- 0x00004501 (compressed) → illegal=1, out_opcode=0, class=0, out_pc passed unchanged.
- Backpressure: hold out_ready=0 and offer A,B,C back-to-back → A in out, B in skid, in_ready=0 while C waits. Release → A,B,C delivered on consecutive cycles, in order.
- Flush with out and skid full plus input D offered → next cycle out_valid=0, in_ready=1, and D never appears. 0x00000073 is legal class bit9 with DECODE_SYSTEM_EN, illegal without.
